lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 195 +++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit master: turns one RV32I byte/half/word access into word-memory cycles.
// Latency: error 1 cycle, load and SW 2 cycles, SB/SH 3 cycles (read-modify-write).
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no stall.
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]  state_q,  state_d;
    logic        we_q,     we_d;
    logic [2:0]  f3_q,     f3_d;
    logic [7:0]  addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] word_q,   word_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        req_legal;
    logic        req_misal;
    logic        req_bad;
    logic [31:0] store_word;

    // Select the addressed lane of a word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = w;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte or half of the previously read word.
    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (f3 == F3_B) begin
            case (lane)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else begin
            if (lane[1]) r[31:16] = d[15:0];
            else         r[15:0]  = d[15:0];
        end
        return r;
    endfunction

    // Classify the incoming request: unsigned codes are load-only, reserved codes never legal.
    always_comb begin
        req_legal = 1'b0;
        req_misal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = ~req_we;
            default:          req_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   req_misal = req_addr[0];
            2'b10:   req_misal = (req_addr[1:0] != 2'b00);
            default: req_misal = 1'b0;
        endcase
        req_bad = ~req_legal | req_misal;
    end

    // Word presented during WR: SW goes straight through, SB/SH merge into the read word.
    always_comb begin
        store_word = (f3_q == F3_W) ? wdata_q : merge(f3_q, addr_q[1:0], word_q, wdata_q);
    end

    // Next-state and capture logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        err_d = 1'b0;
                        if (req_we && req_funct3 == F3_W) state_d = S_WR;
                        else                              state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                word_d = mem_rdata;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext(f3_q, addr_q[1:0], mem_rdata);
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                rdata_d = 32'd0;
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset drops any access in flight without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs; memory strobes are gated by rst so a reset cycle can never write.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = (state_q == S_RESP) & err_q;
        resp_rdata = rdata_q;
        MemRead    = (state_q == S_RD) & ~rst;
        MemWrite   = (state_q == S_WR) & ~rst;
        mem_addr   = addr_q[7:2];
        mem_wdata  = (state_q == S_WR) ? store_word : 32'd0;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: fixed vector table, multi-cycle corner sequences, random traffic.
// Latency: driven one request at a time except the back-to-back sequence.
// Backpressure: waits on req_ready with a bounded cycle budget.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write at rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one access from the ISA rules, updating ref_mem.
    task automatic model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int rcyc, output int wcyc,
                         output logic [31:0] nw);
        int          idx;
        int          nbytes;
        int          sh;
        logic        illegal;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        idx = int'(a) / 4;
        sh  = 8 * (int'(a) % 4);
        w   = ref_mem[idx];
        illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                    (!we && (f3 == 3'd4 || f3 == 3'd5)));
        nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        rd = 0; er = 0; rcyc = 0; wcyc = 0; nw = 0; lat = 0;
        if (illegal || (int'(a) % nbytes) != 0) begin
            er  = 1;
            lat = 1;
        end else if (!we) begin
            lat  = 2;
            rcyc = 1;
            if (nbytes == 4) begin
                rd = w;
            end else begin
                v = (w >> sh) & ((nbytes == 1) ? 32'hFF : 32'hFFFF);
                if (f3 == 3'd0 && v >= 128)   v = v - 256;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                rd = v;
            end
        end else if (nbytes == 4) begin
            lat  = 2;
            wcyc = 1;
            nw   = wd;
            ref_mem[idx] = wd;
        end else begin
            lat  = 3;
            rcyc = 1;
            wcyc = 2;
            mask = ((nbytes == 1) ? 32'hFF : 32'hFFFF) << sh;
            nw   = (w & ~mask) | ((wd << sh) & mask);
            ref_mem[idx] = nw;
        end
    endtask

    // Issue one request, scramble inputs after acceptance, observe until the response.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int rcyc, output int wcyc,
                          output int nrd, output int nwr, output logic [31:0] wdat);
        int guard;
        lat = 0; rd = 0; er = 0; rcyc = 0; wcyc = 0; nrd = 0; nwr = 0; wdat = 0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 8'($urandom);
        req_wdata  = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
            if (MemRead) begin
                nrd++;
                rcyc = c;
            end
            if (MemWrite) begin
                nwr++;
                wcyc = c;
                wdat = mem_wdata;
            end else begin
                chk("wdata_idle_zero", mem_wdata, 32'd0);
            end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("rdata_hold", resp_rdata, rd);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int          lat, rcyc, wcyc, nrd, nwr;
        int          m_lat, m_rcyc, m_wcyc;
        logic [31:0] rd, wdat, m_rd, m_nw;
        logic        er, m_er;
        int          nresp;
        int          rcyc_b2b [2];
        logic [31:0] rdat_b2b [2];
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd;

        tbl[0]  = '{1'b0, 3'd2, 8'h04, 32'h0,        32'h800000F9, 1'b0, 2};
        tbl[1]  = '{1'b0, 3'd0, 8'h04, 32'h0,        32'hFFFFFFF9, 1'b0, 2};
        tbl[2]  = '{1'b0, 3'd4, 8'h04, 32'h0,        32'h000000F9, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'd1, 8'h06, 32'h0,        32'hFFFF8000, 1'b0, 2};
        tbl[4]  = '{1'b1, 3'd0, 8'h09, 32'h000000AB, 32'h0,        1'b0, 3};
        tbl[5]  = '{1'b0, 3'd2, 8'h08, 32'h0,        32'h1122AB44, 1'b0, 2};
        tbl[6]  = '{1'b1, 3'd1, 8'h0D, 32'h12345678, 32'h0,        1'b1, 1};
        tbl[7]  = '{1'b0, 3'd5, 8'h06, 32'h0,        32'h00008000, 1'b0, 2};
        tbl[8]  = '{1'b0, 3'd3, 8'h00, 32'h0,        32'h0,        1'b1, 1};
        tbl[9]  = '{1'b1, 3'd4, 8'h00, 32'h55,       32'h0,        1'b1, 1};
        tbl[10] = '{1'b0, 3'd2, 8'h02, 32'h0,        32'h0,        1'b1, 1};
        tbl[11] = '{1'b1, 3'd1, 8'h0A, 32'h0000BEEF, 32'h0,        1'b0, 3};
        tbl[12] = '{1'b0, 3'd2, 8'h08, 32'h0,        32'hBEEFAB44, 1'b0, 2};
        tbl[13] = '{1'b1, 3'd2, 8'h0C, 32'hCAFEF00D, 32'h0,        1'b0, 2};
        tbl[14] = '{1'b0, 3'd0, 8'h0F, 32'h0,        32'hFFFFFFCA, 1'b0, 2};
        tbl[15] = '{1'b0, 3'd1, 8'h05, 32'h0,        32'h0,        1'b1, 1};

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0BADF00D;
        mem[1] = 32'h800000F9;
        mem[2] = 32'h11223344;
        mem[3] = 32'h76543210;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 8'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, m_lat, m_rd, m_er, m_rcyc, m_wcyc, m_nw);
            run_op(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, rd, er, rcyc, wcyc, nrd, nwr, wdat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_read_cycle", i), 32'(rcyc), 32'(m_rcyc));
            chk($sformatf("tbl%0d_write_cycle", i), 32'(wcyc), 32'(m_wcyc));
            chk($sformatf("tbl%0d_read_count", i), 32'(nrd), 32'(m_rcyc != 0));
            chk($sformatf("tbl%0d_write_count", i), 32'(nwr), 32'(m_wcyc != 0));
            if (m_wcyc != 0) chk($sformatf("tbl%0d_wdata", i), wdat, m_nw);
        end
        chk("sb_word2_memory", mem[2], 32'hBEEFAB44);

        // Reset during the WR cycle of an SW: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 8'h00; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_memwrite_gated", 32'(MemWrite), 32'd0);
        chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_mem_unchanged", mem[0], ref_mem[0]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_late_resp", 32'(resp_valid), 32'd0);
        end

        // Back-to-back loads with req_valid held high.
        nresp = 0;
        rcyc_b2b[0] = 0; rcyc_b2b[1] = 0;
        rdat_b2b[0] = 0; rdat_b2b[1] = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 8'h00;
        @(posedge clk);
        #1 req_addr = 8'h0C;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) req_valid = 1'b0;
            if (resp_valid && nresp < 2) begin
                rcyc_b2b[nresp] = c;
                rdat_b2b[nresp] = resp_rdata;
                nresp++;
            end
        end
        chk("b2b_resp_count", 32'(nresp), 32'd2);
        chk("b2b_first_cycle", 32'(rcyc_b2b[0]), 32'd2);
        chk("b2b_second_cycle", 32'(rcyc_b2b[1]), 32'd5);
        chk("b2b_first_data", rdat_b2b[0], ref_mem[0]);
        chk("b2b_second_data", rdat_b2b[1], ref_mem[3]);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            model(we, f3, a, wd, m_lat, m_rd, m_er, m_rcyc, m_wcyc, m_nw);
            run_op(we, f3, a, wd, lat, rd, er, rcyc, wcyc, nrd, nwr, wdat);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(m_er));
            chk($sformatf("rnd%0d_read_cycle", i), 32'(rcyc), 32'(m_rcyc));
            chk($sformatf("rnd%0d_write_cycle", i), 32'(wcyc), 32'(m_wcyc));
            chk($sformatf("rnd%0d_access_count", i), 32'(nrd + nwr),
                32'((m_rcyc != 0) + (m_wcyc != 0)));
            if (m_wcyc != 0) chk($sformatf("rnd%0d_wdata", i), wdat, m_nw);
        end

        for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
